// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register bank and divider/multiplier handshake sequencer
//
// Purpose:
//   This block issues one-cycle start pulses to the divider (CtoD) and the
//   multiplier (CtoM). It then waits for their done handshakes and captures
//   the 64-bit result into HI/LO. It also serves mthi/mtlo/mfhi/mflo and
//   raises sticky divide-by-zero and handshake-timeout flags.
//
// Ports:
//   Clock, Reset           clock; asynchronous active-high reset
//   DivStart, MultStart    start requests, sampled only in IDLE
//   B                      divisor, checked for zero when DivStart is accepted
//   CtoD / DtoC            divider start pulse / divider done
//   DivHigh, DivLow        divider remainder / quotient
//   CtoM / MtoC            multiplier start pulse / multiplier done
//   MultHigh, MultLow      product upper / lower half
//   MtHi, MtLo, WriteData  direct HI/LO writes, honoured only in IDLE
//   MfHi, MfLo, ReadData   combinational HI/LO read port
//   Busy                   high in every non-IDLE state
//   DivZero, Timeout       sticky error flags
module hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        DivStart,
  input  logic        MultStart,
  input  logic [31:0] B,
  output logic        CtoD,
  input  logic        DtoC,
  input  logic [31:0] DivHigh,
  input  logic [31:0] DivLow,
  output logic        CtoM,
  input  logic        MtoC,
  input  logic [31:0] MultHigh,
  input  logic [31:0] MultLow,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WriteData,
  input  logic        MfHi,
  input  logic        MfLo,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        DivZero,
  output logic        Timeout
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DSTART, DWAIT, MSTART, MWAIT} state_t;

  state_t        state, state_next;
  logic [31:0]   hi, hi_next, lo, lo_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          div_zero_next, timeout_next;

  always_comb begin
    state_next    = state;
    hi_next       = hi;
    lo_next       = lo;
    cnt_next      = cnt;
    div_zero_next = DivZero;
    timeout_next  = Timeout;
    unique case (state)
      IDLE: begin
        // Starts take priority over moves; an accepted start drops MtHi/MtLo.
        if (DivStart) begin
          if (B == '0) begin
            div_zero_next = 1'b1;
          end else begin
            div_zero_next = 1'b0;
            timeout_next  = 1'b0;
            state_next    = DSTART;
          end
        end else if (MultStart) begin
          timeout_next = 1'b0;
          state_next   = MSTART;
        end else begin
          if (MtHi) hi_next = WriteData;
          if (MtLo) lo_next = WriteData;
        end
      end
      DSTART: begin
        cnt_next   = '0;
        state_next = DWAIT;
      end
      DWAIT: begin
        // A done arriving on the last counted cycle still wins over the timeout.
        if (DtoC) begin
          hi_next    = DivHigh;
          lo_next    = DivLow;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      MSTART: begin
        cnt_next   = '0;
        state_next = MWAIT;
      end
      MWAIT: begin
        if (MtoC) begin
          hi_next    = MultHigh;
          lo_next    = MultLow;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Start pulses and Busy are flops loaded from the next state, so the
  // divider (which samples on negedge) sees a clean full-cycle pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      DivZero <= 1'b0;
      Timeout <= 1'b0;
      CtoD    <= 1'b0;
      CtoM    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= state_next;
      hi      <= hi_next;
      lo      <= lo_next;
      cnt     <= cnt_next;
      DivZero <= div_zero_next;
      Timeout <= timeout_next;
      CtoD    <= (state_next == DSTART);
      CtoM    <= (state_next == MSTART);
      Busy    <= (state_next != IDLE);
    end
  end

  assign ReadData = MfHi ? hi : (MfLo ? lo : 32'h0);

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - directed self-checking bench for hilo_ctrl
module tb_hilo_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, DivStart, MultStart, DtoC, MtoC;
  logic        MtHi, MtLo, MfHi, MfLo;
  logic [31:0] B, DivHigh, DivLow, MultHigh, MultLow, WriteData;
  logic        CtoD, CtoM, Busy, DivZero, Timeout;
  logic [31:0] ReadData;

  int checks = 0;
  int errors = 0;

  hilo_ctrl #(.TIMEOUT(40)) dut (
    .Clock(Clock), .Reset(Reset), .DivStart(DivStart), .MultStart(MultStart),
    .B(B), .CtoD(CtoD), .DtoC(DtoC), .DivHigh(DivHigh), .DivLow(DivLow),
    .CtoM(CtoM), .MtoC(MtoC), .MultHigh(MultHigh), .MultLow(MultLow),
    .MtHi(MtHi), .MtLo(MtLo), .WriteData(WriteData), .MfHi(MfHi), .MfLo(MfLo),
    .ReadData(ReadData), .Busy(Busy), .DivZero(DivZero), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  // Inputs change at negedge; the DUT samples them at posedge.
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    MfHi = 1'b1; MfLo = 1'b0; #1; h = ReadData;
    MfHi = 1'b0; MfLo = 1'b1; #1; l = ReadData;
    MfLo = 1'b0; #1;
  endtask

  // Starts an operation and counts Busy/CtoD/CtoM cycles. done_at names the
  // Busy cycle in which done is raised (0 = never). poke raises MultStart
  // while busy but before that cycle.
  task automatic run_op(input bit is_div, input logic [31:0] b, input int done_at,
                        input bit poke, output int busy_n, output int ctod_n,
                        output int ctom_n);
    bit done;
    busy_n = 0; ctod_n = 0; ctom_n = 0;
    B = b;
    if (is_div) DivStart = 1'b1; else MultStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0; MultStart = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!Busy) break;
      busy_n++;
      if (CtoD) ctod_n++;
      if (CtoM) ctom_n++;
      done = (busy_n == done_at);
      DtoC = is_div & done;
      MtoC = !is_div & done;
      MultStart = poke & !done;
      @(negedge Clock);
    end
    DtoC = 1'b0; MtoC = 1'b0; MultStart = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_bound: Busy=%b after %0d cycles, required 0", Busy, busy_n);
    end
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    Reset = 1'b1; DivStart = 0; MultStart = 0; DtoC = 0; MtoC = 0;
    MtHi = 0; MtLo = 0; MfHi = 0; MfLo = 0; B = 0; WriteData = 0;
    DivHigh = 0; DivLow = 0; MultHigh = 0; MultLow = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    read_hilo(h, l);
    checks++;
    if ({CtoD, CtoM, Busy, DivZero, Timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {CtoD, CtoM, Busy, DivZero, Timeout});
    end
    checks++;
    if (h !== 32'h0 || l !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h, required 0/0", h, l);
    end
    checks++;
    if (ReadData !== 32'h0) begin
      errors++;
      $display("FAIL read_none: got %h, required 0", ReadData);
    end
  endtask

  task automatic test_divide;
    int bn, dn, mn;
    logic [31:0] h, l;
    DivHigh = 32'd2; DivLow = 32'd14;
    run_op(1'b1, 32'd7, 33, 1'b0, bn, dn, mn);
    read_hilo(h, l);
    checks++;
    if (bn !== 33 || dn !== 1 || mn !== 0) begin
      errors++;
      $display("FAIL div_timing: busy=%0d ctod=%0d ctom=%0d, required 33/1/0", bn, dn, mn);
    end
    checks++;
    if (h !== 32'd2 || l !== 32'd14) begin
      errors++;
      $display("FAIL div_result: got %h/%h, required 2/e", h, l);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] h, l;
    int ctod_n = 0;
    B = 32'h0; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    if (CtoD) ctod_n++;
    checks++;
    if (DivZero !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_flag: DivZero=%b Busy=%b, required 1/0", DivZero, Busy);
    end
    repeat (3) begin
      @(negedge Clock);
      if (CtoD) ctod_n++;
    end
    read_hilo(h, l);
    checks++;
    if (ctod_n !== 0 || DivZero !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_hold: ctod=%0d DivZero=%b Busy=%b, required 0/1/0", ctod_n, DivZero, Busy);
    end
    checks++;
    if (h !== 32'd2 || l !== 32'd14) begin
      errors++;
      $display("FAIL divzero_hilo: got %h/%h, required 2/e", h, l);
    end
  endtask

  task automatic test_multiply;
    int bn, dn, mn;
    logic [31:0] h, l;
    MultHigh = 32'h1; MultLow = 32'hFFFF_FFFE;
    run_op(1'b0, 32'h0, 6, 1'b0, bn, dn, mn);
    read_hilo(h, l);
    checks++;
    if (bn !== 6 || dn !== 0 || mn !== 1) begin
      errors++;
      $display("FAIL mul_timing: busy=%0d ctod=%0d ctom=%0d, required 6/0/1", bn, dn, mn);
    end
    checks++;
    if (h !== 32'h1 || l !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mul_result: got %h/%h, required 1/fffffffe", h, l);
    end
    checks++;
    if (DivZero !== 1'b1) begin
      errors++;
      $display("FAIL mul_divzero_sticky: got %b, required 1", DivZero);
    end
  endtask

  task automatic test_timeout;
    int bn, dn, mn;
    logic [31:0] h, l;
    DivHigh = 32'hAAAA_AAAA; DivLow = 32'h5555_5555;
    run_op(1'b1, 32'd5, 0, 1'b0, bn, dn, mn);
    checks++;
    if (bn !== 41 || Timeout !== 1'b1 || DivZero !== 1'b0) begin
      errors++;
      $display("FAIL timeout: busy=%0d Timeout=%b DivZero=%b, required 41/1/0", bn, Timeout, DivZero);
    end
    DtoC = 1'b1;
    @(negedge Clock);
    DtoC = 1'b0;
    @(negedge Clock);
    read_hilo(h, l);
    checks++;
    if (h !== 32'h1 || l !== 32'hFFFF_FFFE || Busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done: got %h/%h Busy=%b, required 1/fffffffe/0", h, l, Busy);
    end
  endtask

  task automatic test_move_priority;
    int bn, dn, mn;
    logic [31:0] h, l;
    WriteData = 32'hDEAD_BEEF; MtHi = 1'b1;
    @(negedge Clock);
    MtHi = 1'b0;
    read_hilo(h, l);
    checks++;
    if (h !== 32'hDEAD_BEEF || l !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mthi: got %h/%h, required deadbeef/fffffffe", h, l);
    end
    WriteData = 32'h1357_9BDF; MtHi = 1'b1; MtLo = 1'b1;
    @(negedge Clock);
    MtHi = 1'b0; MtLo = 1'b0;
    read_hilo(h, l);
    checks++;
    if (h !== 32'h1357_9BDF || l !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL mthi_mtlo: got %h/%h, required 13579bdf/13579bdf", h, l);
    end
    // DivStart with MtLo on the same edge; let it time out so LO must keep its old value.
    WriteData = 32'hCAFE_F00D; MtLo = 1'b1;
    run_op(1'b1, 32'd3, 0, 1'b1, bn, dn, mn);
    read_hilo(h, l);
    checks++;
    if (l !== 32'h1357_9BDF || h !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL start_vs_mtlo: got %h/%h, required 13579bdf/13579bdf", h, l);
    end
    checks++;
    if (bn !== 41 || dn !== 1 || mn !== 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_during_busy: busy=%0d ctod=%0d ctom=%0d Busy=%b, required 41/1/0/0", bn, dn, mn, Busy);
    end
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] h, l;
    B = 32'd9; DivHigh = 32'h55; DivLow = 32'h66; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    repeat (5) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    read_hilo(h, l);
    checks++;
    if ({CtoD, CtoM, Busy, DivZero, Timeout} !== 5'b0 || h !== 32'h0 || l !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: flags=%b hilo=%h/%h, required 00000 0/0",
               {CtoD, CtoM, Busy, DivZero, Timeout}, h, l);
    end
    @(negedge Clock);
    Reset = 1'b0;
    DtoC = 1'b1;
    @(negedge Clock);
    DtoC = 1'b0;
    @(negedge Clock);
    read_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_late_done: got %h/%h Busy=%b, required 0/0/0", h, l, Busy);
    end
  endtask

  initial begin
    test_reset;
    test_divide;
    test_div_zero;
    test_multiply;
    test_timeout;
    test_move_priority;
    test_reset_mid_div;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
